// File: rtl/ulpi_phy_responder.sv
// ulpi_phy_responder
// -------------------
// PHY-side model of a ULPI transceiver.
// - Answers link TXCMDs: register read, register write and packet transmit.
// - Injects received USB bytes toward the link using RXCMD framing.
// All outputs are registered except rx_ready. rx_ready is a combinational
// acknowledge of the byte currently presented on rx_byte.
//
// Ports
//   CLKOUT, RESET        60 MHz clock; synchronous active-high reset
//   STP, link_data       link stop strobe and link-driven bus value
//   DIR, NXT, phy_data   PHY bus ownership, throttle and PHY-driven bus value
//   line_state           LineState reported in RXCMD bits [1:0]
//   rx_valid/rx_ready    receive byte handshake (rx_byte, rx_last)
//   tx_byte(_valid)      transmit payload byte stream taken from the link
//   tx_pid, tx_len       PID and saturating byte count of the last packet
//   tx_done              one-cycle pulse at the end of a packet
//   func_ctrl, otg_ctrl  current control register values
//   cmd_abort, reg_err   one-cycle pulses: discarded TXCMD, malformed write
//   dbg_state            current FSM state, for checkers
//
// Optional build macro: ULPI_RXCMD_ON_WRITE_EN
//   When defined, the PHY sends an unsolicited RXCMD after any committed
//   write that changes func_ctrl.
//
// Receive handshake: a byte moves from the source to the PHY on a clock edge
// where rx_valid and rx_ready are both high. rx_ready never depends on
// anything the source drives other than rx_valid. rx_byte and rx_last must
// stay stable while rx_valid is high and rx_ready is low.

module ulpi_phy_responder #(
    parameter logic [15:0] VENDOR_ID     = 16'h0424,
    parameter logic [15:0] PRODUCT_ID    = 16'h0004,
    parameter logic [7:0]  FUNC_CTRL_RST = 8'h41,
    parameter logic [7:0]  OTG_CTRL_RST  = 8'h06
) (
    input  logic       CLKOUT,
    input  logic       RESET,
    input  logic       STP,
    input  logic [7:0] link_data,
    output logic       DIR,
    output logic       NXT,
    output logic [7:0] phy_data,
    input  logic [1:0] line_state,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_last,
    output logic       rx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    output logic [3:0] tx_pid,
    output logic [7:0] tx_len,
    output logic       tx_done,
    output logic [7:0] func_ctrl,
    output logic [7:0] otg_ctrl,
    output logic       cmd_abort,
    output logic       reg_err,
    output logic [4:0] dbg_state
);

    // Each state names what is on the bus while that state is current.
    // Outputs are computed for the next state and registered with it.
    typedef enum logic [4:0] {
        IDLE, WR_CMD, WR_DATA, WR_STP,
        RD_CMD, RD_TURN, RD_DATA, RD_TURN_OUT,
        TX_CMD, TX_DATA,
        RX_TURN, RX_DATA, RX_LAST, RX_END, RX_TURN_OUT,
        UR_TURN, UR_CMD, UR_TURN_OUT
    } state_t;

    state_t     r_state, w_state_nx;
    logic       r_dir, w_dir_nx, r_nxt, w_nxt_nx;
    logic [7:0] r_phy_data, w_phy_nx;
    logic [5:0] r_addr, w_addr_nx;
    logic [7:0] r_wdata, w_wdata_nx;
    logic [7:0] r_tx_byte, w_tx_byte_nx;
    logic       r_tx_bv, w_tx_bv_nx;
    logic [3:0] r_tx_pid, w_tx_pid_nx;
    logic [7:0] r_tx_cnt, w_tx_cnt_nx, r_tx_len, w_tx_len_nx;
    logic       r_tx_done, w_tx_done_nx;
    logic [7:0] r_func_ctrl, w_func_nx, r_otg_ctrl, w_otg_nx;
    logic       r_cmd_abort, w_cmd_abort_nx, r_reg_err, w_reg_err_nx;
    logic [7:0] w_rd_val, w_func_wr, w_otg_wr;
    logic [7:0] w_rxcmd_active, w_rxcmd_idle;

    assign w_rxcmd_active = {2'b00, 2'b01, 2'b00, line_state};
    assign w_rxcmd_idle   = {2'b00, 2'b00, 2'b00, line_state};

    // Register read map.
    always_comb begin
        w_rd_val = 8'h00;
        case (r_addr)
            6'h00:               w_rd_val = VENDOR_ID[7:0];
            6'h01:               w_rd_val = VENDOR_ID[15:8];
            6'h02:               w_rd_val = PRODUCT_ID[7:0];
            6'h03:               w_rd_val = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06: w_rd_val = r_func_ctrl;
            6'h0A, 6'h0B, 6'h0C: w_rd_val = r_otg_ctrl;
            default:             w_rd_val = 8'h00;
        endcase
    end

    // Register values a committed write would produce.
    always_comb begin
        w_func_wr = r_func_ctrl;
        w_otg_wr  = r_otg_ctrl;
        case (r_addr)
            6'h04:   w_func_wr = r_wdata;
            6'h05:   w_func_wr = r_func_ctrl | r_wdata;
            6'h06:   w_func_wr = r_func_ctrl & ~r_wdata;
            6'h0A:   w_otg_wr  = r_wdata;
            6'h0B:   w_otg_wr  = r_otg_ctrl | r_wdata;
            6'h0C:   w_otg_wr  = r_otg_ctrl & ~r_wdata;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx     = r_state;
        w_dir_nx       = 1'b0;
        w_nxt_nx       = 1'b0;
        w_phy_nx       = 8'h00;
        w_addr_nx      = r_addr;
        w_wdata_nx     = r_wdata;
        w_tx_byte_nx   = r_tx_byte;
        w_tx_bv_nx     = 1'b0;
        w_tx_pid_nx    = r_tx_pid;
        w_tx_cnt_nx    = r_tx_cnt;
        w_tx_len_nx    = r_tx_len;
        w_tx_done_nx   = 1'b0;
        // FUNC_CTRL bit5 (Reset) clears itself one cycle after it is set.
        w_func_nx      = r_func_ctrl & 8'hDF;
        w_otg_nx       = r_otg_ctrl;
        w_cmd_abort_nx = 1'b0;
        w_reg_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    // Receive wins; a TXCMD in the same cycle is dropped.
                    w_state_nx     = RX_TURN;
                    w_dir_nx       = 1'b1;
                    w_cmd_abort_nx = (link_data[7:6] != 2'b00);
                end else begin
                    w_addr_nx = link_data[5:0];
                    case (link_data[7:6])
                        2'b01: begin
                            w_state_nx  = TX_CMD;
                            w_nxt_nx    = 1'b1;
                            w_tx_pid_nx = link_data[3:0];
                            w_tx_cnt_nx = 8'h00;
                        end
                        2'b10: begin w_state_nx = WR_CMD; w_nxt_nx = 1'b1; end
                        2'b11: begin w_state_nx = RD_CMD; w_nxt_nx = 1'b1; end
                        default: ;
                    endcase
                end
            end
            WR_CMD: begin
                if (STP) begin w_state_nx = IDLE; w_reg_err_nx = 1'b1; end
                else begin w_state_nx = WR_DATA; w_nxt_nx = 1'b1; end
            end
            WR_DATA: begin
                if (STP) begin w_state_nx = IDLE; w_reg_err_nx = 1'b1; end
                else begin w_state_nx = WR_STP; w_wdata_nx = link_data; end
            end
            WR_STP: begin
                w_state_nx = IDLE;
                if (STP) begin
                    w_func_nx = w_func_wr;
                    w_otg_nx  = w_otg_wr;
`ifdef ULPI_RXCMD_ON_WRITE_EN
                    if (w_func_wr != r_func_ctrl) begin
                        w_state_nx = UR_TURN;
                        w_dir_nx   = 1'b1;
                    end
`endif
                end else begin
                    w_reg_err_nx = 1'b1;
                end
            end
            RD_CMD:      begin w_state_nx = RD_TURN; w_dir_nx = 1'b1; end
            RD_TURN:     begin w_state_nx = RD_DATA; w_dir_nx = 1'b1; w_phy_nx = w_rd_val; end
            RD_DATA:     w_state_nx = RD_TURN_OUT;
            RD_TURN_OUT: w_state_nx = IDLE;
            TX_CMD, TX_DATA: begin
                if (STP) begin
                    w_state_nx   = IDLE;
                    w_tx_len_nx  = r_tx_cnt;
                    w_tx_done_nx = 1'b1;
                end else begin
                    w_state_nx = TX_DATA;
                    w_nxt_nx   = 1'b1;
                    // In TX_CMD the link still holds the TXCMD: not payload.
                    if (r_state == TX_DATA) begin
                        w_tx_byte_nx = link_data;
                        w_tx_bv_nx   = 1'b1;
                        w_tx_cnt_nx  = (r_tx_cnt == 8'hFF) ? r_tx_cnt : r_tx_cnt + 8'd1;
                    end
                end
            end
            RX_TURN: begin
                // First bus cycle after turnaround carries an RxActive RXCMD.
                w_state_nx = RX_DATA;
                w_dir_nx   = 1'b1;
                w_phy_nx   = w_rxcmd_active;
            end
            RX_DATA: begin
                w_dir_nx = 1'b1;
                if (rx_valid) begin
                    w_nxt_nx = 1'b1;
                    w_phy_nx = rx_byte;
                    if (rx_last) w_state_nx = RX_LAST;
                end else begin
                    w_phy_nx = w_rxcmd_active;
                end
            end
            RX_LAST: begin
                w_state_nx = RX_END;
                w_dir_nx   = 1'b1;
                w_phy_nx   = w_rxcmd_idle;
            end
            RX_END:      w_state_nx = RX_TURN_OUT;
            RX_TURN_OUT: w_state_nx = IDLE;
`ifdef ULPI_RXCMD_ON_WRITE_EN
            UR_TURN: begin
                w_state_nx = UR_CMD;
                w_dir_nx   = 1'b1;
                w_phy_nx   = w_rxcmd_idle;
            end
            UR_CMD:      w_state_nx = UR_TURN_OUT;
            UR_TURN_OUT: w_state_nx = IDLE;
`endif
            default:     w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLKOUT) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_nxt       <= 1'b0;
            r_phy_data  <= 8'h00;
            r_addr      <= 6'h00;
            r_wdata     <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_tx_bv     <= 1'b0;
            r_tx_pid    <= 4'h0;
            r_tx_cnt    <= 8'h00;
            r_tx_len    <= 8'h00;
            r_tx_done   <= 1'b0;
            r_func_ctrl <= FUNC_CTRL_RST;
            r_otg_ctrl  <= OTG_CTRL_RST;
            r_cmd_abort <= 1'b0;
            r_reg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_dir       <= w_dir_nx;
            r_nxt       <= w_nxt_nx;
            r_phy_data  <= w_phy_nx;
            r_addr      <= w_addr_nx;
            r_wdata     <= w_wdata_nx;
            r_tx_byte   <= w_tx_byte_nx;
            r_tx_bv     <= w_tx_bv_nx;
            r_tx_pid    <= w_tx_pid_nx;
            r_tx_cnt    <= w_tx_cnt_nx;
            r_tx_len    <= w_tx_len_nx;
            r_tx_done   <= w_tx_done_nx;
            r_func_ctrl <= w_func_nx;
            r_otg_ctrl  <= w_otg_nx;
            r_cmd_abort <= w_cmd_abort_nx;
            r_reg_err   <= w_reg_err_nx;
        end
    end

    assign DIR           = r_dir;
    assign NXT           = r_nxt;
    assign phy_data      = r_phy_data;
    assign rx_ready      = (r_state == RX_DATA) && rx_valid;
    assign tx_byte       = r_tx_byte;
    assign tx_byte_valid = r_tx_bv;
    assign tx_pid        = r_tx_pid;
    assign tx_len        = r_tx_len;
    assign tx_done       = r_tx_done;
    assign func_ctrl     = r_func_ctrl;
    assign otg_ctrl      = r_otg_ctrl;
    assign cmd_abort     = r_cmd_abort;
    assign reg_err       = r_reg_err;
    assign dbg_state     = r_state;

endmodule
